// File: rtl/exe_mem_skid_reg.sv
// EX->MEM stage register: 2-entry skid buffer plus architectural {Z,C,N,V} status.
// Latency: 1 cycle from accept to out_valid when empty; sustains 1 transfer per cycle.
// Backpressure: in_ready is a flop (low only when both entries full), never combinational from out_ready.
// Optional build macro EXE_MEM_FWD_EN adds head/skid forwarding taps for the hazard unit.
module exe_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_res,
    input  logic [3:0]        in_sr,
    input  logic              in_s,
    input  logic              in_wb_en,
    input  logic              in_mem_r,
    input  logic              in_mem_w,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_st_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_res,
    output logic              out_wb_en,
    output logic              out_mem_r,
    output logic              out_mem_w,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_st_val,
`ifdef EXE_MEM_FWD_EN
    output logic              fwd0_v,
    output logic [DEST_W-1:0] fwd0_dest,
    output logic [DATA_W-1:0] fwd0_res,
    output logic              fwd1_v,
    output logic [DEST_W-1:0] fwd1_dest,
    output logic [DATA_W-1:0] fwd1_res,
`endif
    output logic [3:0]        status
);

    // One buffered instruction as it travels toward MEM.
    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              wb_en;
        logic              mem_r;
        logic              mem_w;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] st_val;
    } entry_t;

    // Occupancy: EMPTY = nothing held, ONE = head only, TWO = head + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    entry_t     head_q;
    entry_t     skid_q;
    entry_t     in_ent;
    logic       in_ready_q;
    logic [3:0] status_q;

    logic       accept;
    logic       issue;
    logic       head_ld_in;
    logic       head_ld_skid;
    logic       skid_ld;
    logic       head_vld;
    logic       skid_vld;

    assign in_ent.res    = in_res;
    assign in_ent.wb_en  = in_wb_en;
    assign in_ent.mem_r  = in_mem_r;
    assign in_ent.mem_w  = in_mem_w;
    assign in_ent.dest   = in_dest;
    assign in_ent.st_val = in_st_val;

    assign head_vld = (state_q != EMPTY);
    assign skid_vld = (state_q == TWO);

    assign accept = in_valid & in_ready_q;
    assign issue  = head_vld & out_ready;

    // Next occupancy and which buffer slots load this cycle; flush drops everything.
    always_comb begin
        state_d      = state_q;
        head_ld_in   = 1'b0;
        head_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d    = ONE;
                        head_ld_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !issue) begin
                        state_d = TWO;
                        skid_ld = 1'b1;
                    end else if (accept && issue) begin
                        state_d    = ONE;
                        head_ld_in = 1'b1;
                    end else if (issue) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so no accept can arrive alongside.
                    if (issue) begin
                        state_d      = ONE;
                        head_ld_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State register; in_ready is precomputed from next state so it comes straight off a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    // Buffer slots; fields only change on a load, so the head is stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (head_ld_in) begin
                head_q <= in_ent;
            end else if (head_ld_skid) begin
                head_q <= skid_q;
            end
            if (skid_ld) begin
                skid_q <= in_ent;
            end
        end
    end

    // Flags commit at accept (not issue) so dependent carry users see them next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= 4'b0000;
        end else if (accept && in_s && !flush) begin
            status_q <= in_sr;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = head_vld;
    assign out_res    = head_q.res;
    assign out_wb_en  = head_q.wb_en;
    assign out_mem_r  = head_q.mem_r;
    assign out_mem_w  = head_q.mem_w;
    assign out_dest   = head_q.dest;
    assign out_st_val = head_q.st_val;
    assign status     = status_q;

`ifdef EXE_MEM_FWD_EN
    // Loads are excluded: their value is not known until MEM returns data.
    assign fwd0_v    = head_vld & head_q.wb_en & ~head_q.mem_r;
    assign fwd0_dest = head_q.dest;
    assign fwd0_res  = head_q.res;
    assign fwd1_v    = skid_vld & skid_q.wb_en & ~skid_q.mem_r;
    assign fwd1_dest = skid_q.dest;
    assign fwd1_res  = skid_q.res;
`endif

endmodule
